// File: rtl/mul32_seq_pkg.sv
// Shared ALU definitions for the sequential multiplier (and the divider):
// FSM state encoding, operand width and the {HI, LO} slice positions.
package mul32_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ALU_WIDTH = 32;

    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

endpackage

// File: rtl/mul32_seq_if.sv
// Start/busy/done handshake plus operands and product between control unit and multiplier.
// start is a level request sampled only when the multiplier is idle; busy and done come from the FSM state.
interface mul32_seq_if
    import mul32_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     RegA;
    logic [WIDTH-1:0]     RegB;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   Z;

    modport master (
        output start, RegA, RegB,
        input  busy, done, Z
    );

    modport slave (
        input  start, RegA, RegB,
        output busy, done, Z
    );
endinterface

// File: rtl/mul32_seq_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, q_m1} by one bit.
module booth_step
    import mul32_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   m,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        // Replicate A's sign bit into the vacated MSB while everything moves right.
        {a_next, q_next, q_m1_next} = {sum[WIDTH], sum, q};
    end

endmodule

// File: rtl/mul32_seq.sv
// Multi-cycle signed WIDTH x WIDTH multiplier using radix-2 Booth recoding,
// one add/sub + shift per clock; the 2*WIDTH product is packed as {HI, LO}.
module mul32_seq
    import mul32_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            clear,
    mul32_seq_if.slave      bus,
    output state_t          fsm_state
);
    state_t             state;
    state_t             state_next;

    // A is one bit wider than the operands so M = -2^(WIDTH-1) cannot overflow it.
    logic [WIDTH:0]     a;
    logic [WIDTH:0]     m;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] z;

    logic [WIDTH:0]     a_step;
    logic [WIDTH-1:0]   q_step;
    logic               q_m1_step;
    logic               last_step;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a         (a),
        .m         (m),
        .q         (q),
        .q_m1      (q_m1),
        .a_next    (a_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            a    <= '0;
            m    <= '0;
            q    <= '0;
            q_m1 <= 1'b0;
            cnt  <= '0;
            z    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a    <= '0;
                        m    <= {bus.RegA[WIDTH-1], bus.RegA};
                        q    <= bus.RegB;
                        q_m1 <= 1'b0;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    a    <= a_step;
                    q    <= q_step;
                    q_m1 <= q_m1_step;
                    cnt  <= cnt + CNT_W'(1);
                    // Z is written only with the fully iterated result, never a partial one.
                    if (last_step) begin
                        z <= {a_step[WIDTH-1:0], q_step};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == CALC);
    assign bus.done  = (state == DONE);
    assign bus.Z     = z;
    assign fsm_state = state;

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed corner cases plus random
// operands scored against a plain signed-multiply reference model.
module tb_mul32_seq;
    import mul32_seq_pkg::*;

    logic   clock;
    logic   clear;
    state_t fsm_state;

    mul32_seq_if #(.WIDTH(32)) bus ();

    mul32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock     (clock),
        .clear     (clear),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    logic [63:0] model_z = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Scoreboard: each done pulse must deliver the oldest expected product,
    // and Z must hold the last delivered product (or 0 after reset) otherwise.
    always @(negedge clock) begin
        if (!clear) begin
            exp_q.delete();
            model_z = '0;
        end else if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                model_z = exp_q.pop_front();
                check("z_on_done", bus.Z, model_z);
            end
        end else begin
            check("z_hold", bus.Z, model_z);
        end
    end

    // One operation from a start pulse; optionally injects a stray start pulse
    // while busy (cycle inject_at) that must be ignored.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inject_at);
        int  n;
        int  busy_n;
        bit  seen;
        @(negedge clock);
        bus.RegA  = a;
        bus.RegB  = b;
        bus.start = 1'b1;
        exp_q.push_back(ref_mul(a, b));
        n      = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clock);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (inject_at != 0 && n == inject_at) begin
                bus.RegA  = 32'd1;
                bus.RegB  = 32'd1;
                bus.start = 1'b1;
            end
            if (inject_at != 0 && n == inject_at + 1) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        check("done_latency", 64'(n), 64'd33);
        check("busy_cycles", 64'(busy_n), 64'd32);
        @(negedge clock);
        check("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] pa[3];
        logic [31:0] pb[3];
        int          last_done;
        int          n;
        int          k;

        clear     = 1'b0;
        bus.start = 1'b0;
        bus.RegA  = '0;
        bus.RegB  = '0;
        repeat (3) @(negedge clock);
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_done",  64'(bus.done), 64'd0);
        check("rst_z",     bus.Z, 64'd0);
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        #2 clear = 1'b1;

        run_op(32'd3, 32'd5, 0);
        check("z_3x5", bus.Z, 64'h0000_0000_0000_000F);
        run_op(32'hFFFF_FFF9, 32'd6, 0);
        check("z_m7x6", bus.Z, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op(32'd6, 32'hFFFF_FFF9, 0);
        check("z_6xm7", bus.Z, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op(32'h8000_0000, 32'h8000_0000, 0);
        check("z_min_sq", bus.Z, 64'h4000_0000_0000_0000);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("z_min_xm1", bus.Z, 64'h0000_0000_8000_0000);

        // Stray start at busy cycle 10 must not disturb 12*12.
        run_op(32'd12, 32'd12, 10);
        check("z_12x12", bus.Z, 64'h90);
        repeat (3) @(negedge clock);
        check("no_queued_start", 64'(bus.busy), 64'd0);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clock);
        bus.RegA  = 32'h7FFF_FFFF;
        bus.RegB  = 32'd2;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(negedge clock);
        #2 clear = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_z",    bus.Z, 64'd0);
        @(negedge clock);
        #2 clear = 1'b1;
        run_op(32'h7FFF_FFFF, 32'd2, 0);
        check("z_after_abort", bus.Z, 64'h0000_0000_FFFF_FFFE);

        // Start held high: back-to-back operations 34 cycles apart.
        pa[0] = $urandom; pb[0] = $urandom;
        pa[1] = 32'h8000_0000; pb[1] = $urandom;
        pa[2] = $urandom; pb[2] = 32'hFFFF_FFFF;
        @(negedge clock);
        bus.RegA  = pa[0];
        bus.RegB  = pb[0];
        bus.start = 1'b1;
        exp_q.push_back(ref_mul(pa[0], pb[0]));
        n         = 0;
        last_done = -1;
        k         = 0;
        while (k < 3 && n < 200) begin
            @(negedge clock);
            n++;
            if (bus.done) begin
                if (last_done >= 0) check("b2b_spacing", 64'(n - last_done), 64'd34);
                last_done = n;
                k++;
                if (k < 3) begin
                    bus.RegA = pa[k];
                    bus.RegB = pb[k];
                    exp_q.push_back(ref_mul(pa[k], pb[k]));
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        if (k < 3) check("b2b_timeout", 64'(k), 64'd3);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        check("b2b_idle", 64'(fsm_state), 64'(IDLE));

        // Random operands, biased toward sign and magnitude extremes.
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       rb = 32'hFFFF_FFFF;
                1:       rb = 32'($urandom_range(0, 255));
                default: rb = $urandom;
            endcase
            run_op(ra, rb, (i % 4 == 0) ? int'($urandom_range(2, 30)) : 0);
        end

        repeat (2) @(negedge clock);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
